// File: rtl/input_pkg.sv
// input_pkg: shared sizes and defaults for the switch/button debouncer
package input_pkg;
    localparam int NUM_SW                  = 16;
    localparam int NUM_BTN                 = 2;
    localparam int NUM_CH                  = NUM_SW + NUM_BTN;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one input's synchronizer, stability counter and accepted clean level
module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic raw_i,
    output logic clean_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   differ, done;

    // Accept the synchronized level once it has differed from the clean level long enough;
    // any agreement restarts the count, and the count never runs past LAST.
    always_comb begin
        differ  = sync_q[SYNC_STAGES-1] ^ clean_q;
        done    = differ && (cnt_q == LAST);
        cnt_d   = (differ && !done) ? cnt_q + 1'b1 : '0;
        clean_d = done ? sync_q[SYNC_STAGES-1] : clean_q;
    end

    // Synchronizer chain, counter and clean level, all cleared asynchronously
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;
endmodule

// File: rtl/input_debounce.sv
// input_debounce: debounces 16 switches and 2 buttons, with registered button press pulses
module input_debounce
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [15:0]   Sw,
    input  logic [1:0]    Btn,
    output logic [15:0]   SwClean,
    output logic [1:0]    BtnClean,
    output logic [1:0]    BtnPress
);
    logic [NUM_CH-1:0]  raw, clean;
    logic [NUM_BTN-1:0] btn_prev_q, press_q;

    assign raw = {Btn, Sw};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_chan (
            .Clk    (Clk),
            .Reset_n(Reset_n),
            .raw_i  (raw[g]),
            .clean_o(clean[g])
        );
    end

    // Registered rising-edge detect on the clean button levels
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_prev_q <= '0;
            press_q    <= '0;
        end else begin
            btn_prev_q <= clean[NUM_CH-1:NUM_SW];
            press_q    <= clean[NUM_CH-1:NUM_SW] & ~btn_prev_q;
        end
    end

    assign SwClean  = clean[NUM_SW-1:0];
    assign BtnClean = clean[NUM_CH-1:NUM_SW];
    assign BtnPress = press_q;
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed scoreboard bench for input_debounce with a 4-cycle debounce window
module tb_input_debounce;
    logic        Clk;
    logic        Reset_n;
    logic [15:0] Sw;
    logic [1:0]  Btn;
    logic [15:0] SwClean;
    logic [1:0]  BtnClean;
    logic [1:0]  BtnPress;

    typedef struct {
        int          at;
        string       tag;
        logic [15:0] sw;
        logic [1:0]  bc;
        logic [1:0]  bp;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    input_debounce #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Sw      (Sw),
        .Btn     (Btn),
        .SwClean (SwClean),
        .BtnClean(BtnClean),
        .BtnPress(BtnPress)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic exp_at(input int d, input string tag, input logic [15:0] sw,
                          input logic [1:0] bc, input logic [1:0] bp);
        exp_t e;
        int   i;
        e.at  = cyc + d;
        e.tag = tag;
        e.sw  = sw;
        e.bc  = bc;
        e.bp  = bp;
        i = q.size();
        while (i > 0 && q[i-1].at > e.at) i--;
        q.insert(i, e);
    endtask

    task automatic exp_span(input int d0, input int d1, input string tag, input logic [15:0] sw,
                            input logic [1:0] bc, input logic [1:0] bp);
        for (int d = d0; d <= d1; d++) exp_at(d, tag, sw, bc, bp);
    endtask

    task automatic chk_now(input string tag, input logic [15:0] sw, input logic [1:0] bc,
                           input logic [1:0] bp);
        total++;
        assert ({SwClean, BtnClean, BtnPress} === {sw, bc, bp}) else begin
            bad++;
            $error("FAIL %s cyc=%0d got sw=%h bc=%b bp=%b exp sw=%h bc=%b bp=%b",
                   tag, cyc, SwClean, BtnClean, BtnPress, sw, bc, bp);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].at <= cyc) begin
                e = q.pop_front();
                total++;
                assert (e.at == cyc && {SwClean, BtnClean, BtnPress} === {e.sw, e.bc, e.bp}) else begin
                    bad++;
                    $error("FAIL %s cyc=%0d due=%0d got sw=%h bc=%b bp=%b exp sw=%h bc=%b bp=%b",
                           e.tag, cyc, e.at, SwClean, BtnClean, BtnPress, e.sw, e.bc, e.bp);
                end
            end
        end
    endtask

    initial begin
        Sw      = 16'hFFFF;
        Btn     = 2'b11;
        Reset_n = 1'b0;
        step(3);
        chk_now("rst_hold", 16'h0000, 2'b00, 2'b00);
        Reset_n = 1'b1;
        exp_span(1, 5, "rel_wait", 16'h0000, 2'b00, 2'b00);
        exp_at(6, "rel_clean", 16'hFFFF, 2'b11, 2'b00);
        exp_at(7, "rel_press", 16'hFFFF, 2'b11, 2'b11);
        exp_at(8, "rel_after", 16'hFFFF, 2'b11, 2'b00);
        step(8);

        Sw  = 16'h0000;
        Btn = 2'b00;
        exp_span(1, 5, "fall_wait", 16'hFFFF, 2'b11, 2'b00);
        exp_span(6, 8, "fall_clean", 16'h0000, 2'b00, 2'b00);
        step(8);

        Btn = 2'b10;
        exp_span(1, 5, "p1_wait", 16'h0000, 2'b00, 2'b00);
        exp_at(6, "p1_clean", 16'h0000, 2'b10, 2'b00);
        exp_at(7, "p1_press", 16'h0000, 2'b10, 2'b10);
        exp_span(8, 9, "p1_after", 16'h0000, 2'b10, 2'b00);
        step(9);
        Btn = 2'b00;
        exp_span(1, 5, "p1_hold", 16'h0000, 2'b10, 2'b00);
        exp_span(6, 7, "p1_rel", 16'h0000, 2'b00, 2'b00);
        step(7);

        exp_span(1, 13, "bnc_wait", 16'h0000, 2'b00, 2'b00);
        exp_at(14, "bnc_clean", 16'h0000, 2'b01, 2'b00);
        exp_at(15, "bnc_press", 16'h0000, 2'b01, 2'b01);
        exp_span(16, 17, "bnc_after", 16'h0000, 2'b01, 2'b00);
        Btn = 2'b01; step(2);
        Btn = 2'b00; step(2);
        Btn = 2'b01; step(2);
        Btn = 2'b00; step(2);
        Btn = 2'b01; step(9);
        Btn = 2'b00;
        exp_span(6, 7, "bnc_rel", 16'h0000, 2'b00, 2'b00);
        step(7);

        Sw = 16'h0008;
        exp_span(1, 10, "glitch", 16'h0000, 2'b00, 2'b00);
        step(3);
        Sw = 16'h0000;
        step(7);

        Sw = 16'h00A5;
        exp_span(6, 7, "sim_pre", 16'h00A5, 2'b00, 2'b00);
        step(7);
        Sw = 16'h5A00;
        exp_span(1, 5, "sim_old", 16'h00A5, 2'b00, 2'b00);
        exp_span(6, 8, "sim_new", 16'h5A00, 2'b00, 2'b00);
        step(8);
        Sw = 16'h0000;
        exp_span(6, 7, "sim_clr", 16'h0000, 2'b00, 2'b00);
        step(7);

        Sw = 16'h0001;
        exp_span(1, 4, "mrst_pre", 16'h0000, 2'b00, 2'b00);
        step(4);
        Reset_n = 1'b0;
        #1;
        chk_now("mrst_hold", 16'h0000, 2'b00, 2'b00);
        #1;
        Reset_n = 1'b1;
        exp_span(1, 5, "mrst_restart", 16'h0000, 2'b00, 2'b00);
        exp_at(6, "mrst_clean", 16'h0001, 2'b00, 2'b00);
        step(7);

        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain left=%0d exp 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
